operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, the operand and writeback data width.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port inValid  input  1  decoded instruction present.
REQ-005 The block SHALL have port inReady  output  1  instruction accepted this cycle when high together with inValid.
REQ-006 The block SHALL have ports inRegA, inRegB, inDest  input  5 each  source A, source B and destination register numbers.
REQ-007 The block SHALL have port inWrEn  input  1  instruction will write inDest.
REQ-008 The block SHALL have ports rdAddrA, rdAddrB  output  5 each  register file read addresses.
REQ-009 The block SHALL have ports rdDataA, rdDataB  input  DATA_W each  combinational register file read data.
REQ-010 The block SHALL have ports wbWrite  input  1, wbAddr  input  5, wbData  input  DATA_W  writeback port, identical to the register file write port.
REQ-011 The block SHALL have ports outValid  output  1 and outReady  input  1  output handshake.
REQ-012 The block SHALL have ports outDataA, outDataB  output  DATA_W, outDest  output  5, outWrEn  output  1  registered operands and destination.
REQ-013 The block SHALL have port stallCount  output  16  count of stall cycles.

Function
REQ-014 rdAddrA SHALL equal inRegA and rdAddrB SHALL equal inRegB combinationally.
REQ-015 Operand A SHALL be wbData when wbWrite is high and wbAddr equals inRegA, and rdDataA otherwise; operand B SHALL be selected by the same rule using inRegB.
REQ-016 A 32-bit scoreboard busy[31:0] SHALL mark registers with an accepted but not yet written-back writer.
REQ-017 hazard SHALL be high when busy[inRegA], busy[inRegB], or (inWrEn and busy[inDest]) is set, where a busy bit being cleared by wbWrite in the same cycle SHALL count as not set.
REQ-018 inReady SHALL equal (not rst) and (not hazard) and ((not outValid) or outReady).
REQ-019 An accept (inValid and inReady) SHALL load outDataA/B with the forwarded operands and outDest/outWrEn with inDest/inWrEn, and SHALL set outValid on the next edge, giving a latency of 1 cycle.
REQ-020 Without an accept, outReady high SHALL clear outValid, and outReady low SHALL hold all out* registers unchanged.
REQ-021 An accept with inWrEn high SHALL set busy[inDest].
REQ-022 wbWrite high SHALL clear busy[wbAddr].
REQ-023 When a set and a clear of the same busy bit occur in the same cycle, the set SHALL win.
REQ-024 A wbWrite to a register whose busy bit is clear SHALL be legal and SHALL leave the bit clear.
REQ-025 stallCount SHALL increment in each cycle with inValid high and inReady low, and SHALL saturate at 16'hFFFF.
REQ-026 No register number SHALL be special; register 0 and register 31 SHALL be tracked and forwarded like all others.

Reset
REQ-027 When rst is high at a clock edge, outValid, outWrEn, outDest, outDataA, outDataB, busy and stallCount SHALL all become 0.
REQ-028 An in-flight output or a pending busy bit SHALL be discarded by rst without further handshake.
REQ-029 inReady SHALL be low during any cycle in which rst is high.

Verification
REQ-030 The bench SHALL check: reset, then reg 8 = 64'hAAAAAAAAAAAAAAAA in the register file, inRegA=8, inRegB=0, inValid=1 -> next cycle outValid=1 and outDataA=64'hAAAAAAAAAAAAAAAA.
REQ-031 The bench SHALL check: accept inWrEn=1, inDest=15, then issue inRegA=15 -> inReady=0 and stallCount increments each cycle until wbWrite to addr 15 with wbData 64'hCCCCCCCCCCCCCCCC, in which cycle inReady=1 and outDataA=64'hCCCCCCCCCCCCCCCC next cycle.
REQ-032 The bench SHALL check: outReady=0 with outValid=1 -> inReady=0 and outputs stable for 5 cycles; then outReady=1 -> the queued instruction is accepted.
REQ-033 The bench SHALL check: in the same cycle, wbWrite addr 31 and an accept with inDest=31, inWrEn=1 -> busy[31]=1 afterwards (set wins).
REQ-034 The bench SHALL check: rst asserted with outValid=1 and busy[8]=1 -> next cycle outValid=0, busy=0 and stallCount=0.
REQ-035 The bench SHALL check: hold a hazard for 70000 cycles -> stallCount=16'hFFFF and it does not wrap.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads two sources with writeback forwarding, tracks pending
// writers in a busy scoreboard, and holds one registered instruction for the next stage.
module operand_fetch #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  output logic              inReady,
  input  logic [4:0]        inRegA,
  input  logic [4:0]        inRegB,
  input  logic [4:0]        inDest,
  input  logic              inWrEn,
  output logic [4:0]        rdAddrA,
  output logic [4:0]        rdAddrB,
  input  logic [DATA_W-1:0] rdDataA,
  input  logic [DATA_W-1:0] rdDataB,
  input  logic              wbWrite,
  input  logic [4:0]        wbAddr,
  input  logic [DATA_W-1:0] wbData,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outDataA,
  output logic [DATA_W-1:0] outDataB,
  output logic [4:0]        outDest,
  output logic              outWrEn,
  output logic [15:0]       stallCount
);

  logic [31:0]       busy_reg;
  logic [31:0]       busy_next;
  logic [31:0]       wb_clear;
  logic [31:0]       busy_eff;
  logic [31:0]       dest_set;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_a_reg;
  logic [DATA_W-1:0] out_data_b_reg;
  logic [4:0]        out_dest_reg;
  logic              out_wr_en_reg;
  logic [15:0]       stall_reg;

  assign rdAddrA = inRegA;
  assign rdAddrB = inRegB;

  assign fwd_a = (wbWrite && (wbAddr == inRegA)) ? wbData : rdDataA;
  assign fwd_b = (wbWrite && (wbAddr == inRegB)) ? wbData : rdDataB;

  // busy_eff already excludes bits being written back this cycle, so a
  // same-cycle writeback releases the hazard immediately.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_busy
      assign wb_clear[gi]  = wbWrite && (wbAddr == 5'(gi));
      assign busy_eff[gi]  = busy_reg[gi] & ~wb_clear[gi];
      assign dest_set[gi]  = accept && inWrEn && (inDest == 5'(gi));
      assign busy_next[gi] = dest_set[gi] | busy_eff[gi];
    end
  endgenerate

  assign hazard  = busy_eff[inRegA] | busy_eff[inRegB] | (inWrEn & busy_eff[inDest]);
  assign inReady = ~rst & ~hazard & (~out_valid_reg | outReady);
  assign accept  = inValid & inReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg       <= '0;
      out_valid_reg  <= 1'b0;
      out_data_a_reg <= '0;
      out_data_b_reg <= '0;
      out_dest_reg   <= '0;
      out_wr_en_reg  <= 1'b0;
      stall_reg      <= '0;
    end else begin
      busy_reg <= busy_next;
      if (accept) begin
        out_valid_reg  <= 1'b1;
        out_data_a_reg <= fwd_a;
        out_data_b_reg <= fwd_b;
        out_dest_reg   <= inDest;
        out_wr_en_reg  <= inWrEn;
      end else if (outReady) begin
        out_valid_reg <= 1'b0;
      end
      if (inValid && !inReady && (stall_reg != 16'hFFFF)) begin
        stall_reg <= stall_reg + 16'd1;
      end
    end
  end

  assign outValid   = out_valid_reg;
  assign outDataA   = out_data_a_reg;
  assign outDataB   = out_data_b_reg;
  assign outDest    = out_dest_reg;
  assign outWrEn    = out_wr_en_reg;
  assign stallCount = stall_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file behind the read ports.
module tb_operand_fetch;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              inValid;
  logic              inReady;
  logic [4:0]        inRegA;
  logic [4:0]        inRegB;
  logic [4:0]        inDest;
  logic              inWrEn;
  logic [4:0]        rdAddrA;
  logic [4:0]        rdAddrB;
  logic [DATA_W-1:0] rdDataA;
  logic [DATA_W-1:0] rdDataB;
  logic              wbWrite;
  logic [4:0]        wbAddr;
  logic [DATA_W-1:0] wbData;
  logic              outValid;
  logic              outReady;
  logic [DATA_W-1:0] outDataA;
  logic [DATA_W-1:0] outDataB;
  logic [4:0]        outDest;
  logic              outWrEn;
  logic [15:0]       stallCount;

  logic [DATA_W-1:0] regs [32];
  int checks = 0;
  int failures = 0;
  int base;

  always #5 clk = ~clk;

  operand_fetch #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .inValid(inValid), .inReady(inReady),
    .inRegA(inRegA), .inRegB(inRegB), .inDest(inDest), .inWrEn(inWrEn),
    .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .rdDataA(rdDataA), .rdDataB(rdDataB),
    .wbWrite(wbWrite), .wbAddr(wbAddr), .wbData(wbData),
    .outValid(outValid), .outReady(outReady),
    .outDataA(outDataA), .outDataB(outDataB), .outDest(outDest), .outWrEn(outWrEn),
    .stallCount(stallCount)
  );

  function automatic logic [63:0] init_val(input int i);
    if (i == 8) return 64'hAAAAAAAAAAAAAAAA;
    if (i == 0) return 64'h0123456789ABCDEF;
    return {16'hFEED, 8'(i), 32'h0, 8'(i)};
  endfunction

  // Register file model: reloads on reset, written through the writeback port.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
    end else if (wbWrite) begin
      regs[wbAddr] <= wbData;
    end
  end

  assign rdDataA = regs[rdAddrA];
  assign rdDataB = regs[rdAddrB];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d, input logic we);
    inValid = 1'b1;
    inRegA  = a;
    inRegB  = b;
    inDest  = d;
    inWrEn  = we;
  endtask

  initial begin
    rst = 1'b1; outReady = 1'b1; wbWrite = 1'b0; wbAddr = '0; wbData = '0;
    issue(5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    check("ready_in_reset", 64'(inReady), 64'd0);
    tick;
    tick;
    check("rst_outValid", 64'(outValid), 64'd0);
    check("rst_outDataA", outDataA, 64'd0);
    check("rst_stall", 64'(stallCount), 64'd0);
    rst = 1'b0;

    // Basic fetch, latency 1, register 0 forwarded like any other
    issue(5'd8, 5'd0, 5'd0, 1'b0);
    #1;
    check("t1_ready", 64'(inReady), 64'd1);
    check("t1_rdAddrA", 64'(rdAddrA), 64'd8);
    tick;
    check("t1_outValid", 64'(outValid), 64'd1);
    check("t1_outDataA", outDataA, 64'hAAAAAAAAAAAAAAAA);
    check("t1_outDataB", outDataB, 64'h0123456789ABCDEF);

    // RAW hazard on r15, released by writeback with forwarding
    issue(5'd1, 5'd2, 5'd15, 1'b1);
    tick;
    check("t2_outDest", 64'(outDest), 64'd15);
    check("t2_outWrEn", 64'(outWrEn), 64'd1);
    issue(5'd15, 5'd2, 5'd0, 1'b0);
    base = stallCount;
    for (int k = 1; k <= 3; k++) begin
      #1;
      check("t2_stall_ready", 64'(inReady), 64'd0);
      tick;
      check("t2_stall_count", 64'(stallCount), 64'(base + k));
    end
    wbWrite = 1'b1; wbAddr = 5'd15; wbData = 64'hCCCCCCCCCCCCCCCC;
    #1;
    check("t2_wb_ready", 64'(inReady), 64'd1);
    tick;
    wbWrite = 1'b0;
    check("t2_fwd_A", outDataA, 64'hCCCCCCCCCCCCCCCC);
    check("t2_stall_hold", 64'(stallCount), 64'(base + 3));

    // Back-pressure holds outputs
    outReady = 1'b0;
    issue(5'd3, 5'd4, 5'd0, 1'b0);
    base = stallCount;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check("t3_bp_ready", 64'(inReady), 64'd0);
      tick;
      check("t3_bp_valid", 64'(outValid), 64'd1);
      check("t3_bp_dataA", outDataA, 64'hCCCCCCCCCCCCCCCC);
      check("t3_bp_stall", 64'(stallCount), 64'(base + k));
    end
    outReady = 1'b1;
    #1;
    check("t3_release_ready", 64'(inReady), 64'd1);
    tick;
    check("t3_dataA", outDataA, init_val(3));
    check("t3_dataB", outDataB, init_val(4));

    // Same-cycle set and clear of busy[31]: set wins, operand forwarded
    issue(5'd1, 5'd2, 5'd31, 1'b1);
    #1;
    check("t4_first_ready", 64'(inReady), 64'd1);
    tick;
    issue(5'd31, 5'd31, 5'd31, 1'b1);
    wbWrite = 1'b1; wbAddr = 5'd31; wbData = 64'h3131313131313131;
    #1;
    check("t4_setclr_ready", 64'(inReady), 64'd1);
    tick;
    wbWrite = 1'b0;
    check("t4_fwd_A", outDataA, 64'h3131313131313131);
    check("t4_fwd_B", outDataB, 64'h3131313131313131);
    issue(5'd31, 5'd0, 5'd0, 1'b0);
    #1;
    check("t4_busy31_set", 64'(inReady), 64'd0);
    inValid = 1'b0; wbWrite = 1'b1; wbAddr = 5'd31;
    tick;
    wbWrite = 1'b0;

    // Reset discards in-flight output and busy[8]
    issue(5'd1, 5'd2, 5'd8, 1'b1);
    tick;
    inValid = 1'b0; outReady = 1'b0;
    tick;
    check("t5_pre_valid", 64'(outValid), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_ready", 64'(inReady), 64'd0);
    tick;
    rst = 1'b0;
    check("t5_outValid", 64'(outValid), 64'd0);
    check("t5_stall", 64'(stallCount), 64'd0);
    check("t5_outDest", 64'(outDest), 64'd0);
    check("t5_outWrEn", 64'(outWrEn), 64'd0);
    outReady = 1'b1;
    issue(5'd8, 5'd0, 5'd0, 1'b0);
    #1;
    check("t5_busy_clear", 64'(inReady), 64'd1);
    tick;
    check("t5_dataA", outDataA, 64'hAAAAAAAAAAAAAAAA);

    // Long hazard saturates the stall counter
    issue(5'd1, 5'd2, 5'd5, 1'b1);
    tick;
    issue(5'd5, 5'd0, 5'd0, 1'b0);
    repeat (65534) tick;
    check("t6_stall_fffe", 64'(stallCount), 64'hFFFE);
    tick;
    check("t6_stall_ffff", 64'(stallCount), 64'hFFFF);
    repeat (4465) tick;
    check("t6_stall_sat", 64'(stallCount), 64'hFFFF);
    check("t6_ready", 64'(inReady), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
